hazard_fwd_unit: RTL and testbench

//  Parametrised successor to the 2-source EX forwarding mux select logic.

---
 rtl/hazard_fwd_unit.sv | 124 ++++++++++++
 tb/tb_hazard_fwd_unit.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_unit.sv
// EX-stage forwarding select, ID-stage stall generation and a pending-register
// scoreboard that tracks long-latency (MUL/DIV) ops in flight.
module hazard_fwd_unit #(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned RA_W    = 5,
  parameter int unsigned MAX_OUT = 4,
  parameter int unsigned CNT_W   = 3
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [NUM_SRC*RA_W-1:0] i_ex_rs,
  input  logic [RA_W-1:0]         i_ex_mem_rd,
  input  logic                    i_ex_mem_regwrite,
  input  logic [RA_W-1:0]         i_mem_wb_rd,
  input  logic                    i_mem_wb_regwrite,
  input  logic [NUM_SRC*RA_W-1:0] i_id_rs,
  input  logic [NUM_SRC-1:0]      i_id_rs_used,
  input  logic [RA_W-1:0]         i_id_rd,
  input  logic                    i_id_regwrite,
  input  logic                    i_id_is_long,
  input  logic [RA_W-1:0]         i_id_ex_rd,
  input  logic                    i_id_ex_is_load,
  input  logic                    i_issue_valid,
  input  logic [RA_W-1:0]         i_issue_rd,
  input  logic                    i_lc_wb_valid,
  input  logic [RA_W-1:0]         i_lc_wb_rd,
  output logic [2*NUM_SRC-1:0]    o_fwd_sel,
  output logic                    o_stall,
  output logic [CNT_W-1:0]        o_outstanding,
  output logic                    o_sb_err
);

  localparam int unsigned NumRegs = 1 << RA_W;

  logic [NumRegs-1:0] r_pending;
  logic [CNT_W-1:0]   r_outstanding;
  logic               r_sb_err;

  logic [NumRegs-1:0] w_pending_d;
  logic [CNT_W-1:0]   w_outstanding_d;
  logic               w_sb_err_d;
  logic [NUM_SRC-1:0] w_src_stall;
  logic               w_full;
  logic               w_clr;
  logic               w_dup;
  logic               w_drop_full;
  logic               w_issue;
  logic               w_waw;

  assign w_full = (r_outstanding == CNT_W'(MAX_OUT));

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    logic [RA_W-1:0] w_ex_rs;
    logic [RA_W-1:0] w_id_rs;
    logic [1:0]      w_sel;
    logic            w_load_use;
    logic            w_raw;

    assign w_ex_rs = i_ex_rs[g*RA_W +: RA_W];
    assign w_id_rs = i_id_rs[g*RA_W +: RA_W];

    always_comb begin
      w_sel = 2'b00;
      if (w_ex_rs != '0) begin
        if (i_ex_mem_regwrite && (i_ex_mem_rd == w_ex_rs)) begin
          w_sel = 2'b10;
        end else if (i_mem_wb_regwrite && (i_mem_wb_rd == w_ex_rs)) begin
          w_sel = 2'b01;
        end else if (i_lc_wb_valid && (i_lc_wb_rd == w_ex_rs)) begin
          w_sel = 2'b11;
        end
      end
    end

    assign o_fwd_sel[2*g +: 2] = w_sel;

    assign w_load_use = i_id_ex_is_load && (i_id_ex_rd == w_id_rs);
    // A result landing on the long-op bus this cycle is forwarded, so no RAW stall.
    assign w_raw = r_pending[w_id_rs] && !(i_lc_wb_valid && (i_lc_wb_rd == w_id_rs));
    assign w_src_stall[g] = i_id_rs_used[g] && (w_id_rs != '0) && (w_load_use || w_raw);
  end

  assign w_waw   = i_id_regwrite && (i_id_rd != '0) && r_pending[i_id_rd];
  assign o_stall = (|w_src_stall) || w_waw || (i_id_is_long && w_full);

  always_comb begin
    w_clr = i_lc_wb_valid && r_pending[i_lc_wb_rd];
    // Reissuing a register that retires in the same cycle is legal.
    w_dup = r_pending[i_issue_rd] && !(w_clr && (i_lc_wb_rd == i_issue_rd));
    w_drop_full = w_full && !w_clr;
    w_issue = i_issue_valid && (i_issue_rd != '0) && !w_drop_full && !w_dup;

    w_pending_d = r_pending;
    if (w_clr) w_pending_d[i_lc_wb_rd] = 1'b0;
    if (w_issue) w_pending_d[i_issue_rd] = 1'b1;

    w_outstanding_d = r_outstanding;
    if (w_issue && !w_clr && !w_full) begin
      w_outstanding_d = r_outstanding + CNT_W'(1);
    end else if (!w_issue && w_clr && (r_outstanding != '0)) begin
      w_outstanding_d = r_outstanding - CNT_W'(1);
    end

    w_sb_err_d = r_sb_err
               || (i_lc_wb_valid && !r_pending[i_lc_wb_rd])
               || (i_issue_valid && (w_drop_full || w_dup));
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pending     <= '0;
      r_outstanding <= '0;
      r_sb_err      <= 1'b0;
    end else begin
      r_pending     <= w_pending_d;
      r_outstanding <= w_outstanding_d;
      r_sb_err      <= w_sb_err_d;
    end
  end

  assign o_outstanding = r_outstanding;
  assign o_sb_err      = r_sb_err;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed scenarios plus a randomized run against a register-set reference model.
module tb_hazard_fwd_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] ex_rs;
  logic [4:0] ex_mem_rd;
  logic       ex_mem_regwrite;
  logic [4:0] mem_wb_rd;
  logic       mem_wb_regwrite;
  logic [9:0] id_rs;
  logic [1:0] id_rs_used;
  logic [4:0] id_rd;
  logic       id_regwrite;
  logic       id_is_long;
  logic [4:0] id_ex_rd;
  logic       id_ex_is_load;
  logic       issue_valid;
  logic [4:0] issue_rd;
  logic       lc_wb_valid;
  logic [4:0] lc_wb_rd;
  logic [3:0] fwd_sel;
  logic       stall;
  logic [2:0] outstanding;
  logic       sb_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hazard_fwd_unit #(
    .NUM_SRC(2), .RA_W(5), .MAX_OUT(4), .CNT_W(3)
  ) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_ex_rs           (ex_rs),
    .i_ex_mem_rd       (ex_mem_rd),
    .i_ex_mem_regwrite (ex_mem_regwrite),
    .i_mem_wb_rd       (mem_wb_rd),
    .i_mem_wb_regwrite (mem_wb_regwrite),
    .i_id_rs           (id_rs),
    .i_id_rs_used      (id_rs_used),
    .i_id_rd           (id_rd),
    .i_id_regwrite     (id_regwrite),
    .i_id_is_long      (id_is_long),
    .i_id_ex_rd        (id_ex_rd),
    .i_id_ex_is_load   (id_ex_is_load),
    .i_issue_valid     (issue_valid),
    .i_issue_rd        (issue_rd),
    .i_lc_wb_valid     (lc_wb_valid),
    .i_lc_wb_rd        (lc_wb_rd),
    .o_fwd_sel         (fwd_sel),
    .o_stall           (stall),
    .o_outstanding     (outstanding),
    .o_sb_err          (sb_err)
  );

  task automatic idle_inputs();
    rst_n = 1'b1; ex_rs = '0; ex_mem_rd = '0; ex_mem_regwrite = 1'b0;
    mem_wb_rd = '0; mem_wb_regwrite = 1'b0; id_rs = '0; id_rs_used = '0;
    id_rd = '0; id_regwrite = 1'b0; id_is_long = 1'b0; id_ex_rd = '0;
    id_ex_is_load = 1'b0; issue_valid = 1'b0; issue_rd = '0;
    lc_wb_valid = 1'b0; lc_wb_rd = '0;
  endtask

  // Advance one clock edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_tests++;
    if (outstanding !== 3'd0 || sb_err !== 1'b0 || stall !== 1'b0 || fwd_sel !== 4'b0) begin
      n_fail++;
      $display("FAIL reset: out=%0d err=%b stall=%b fwd=%b, want 0 0 0 0000",
               outstanding, sb_err, stall, fwd_sel);
    end
  endtask

  task automatic test_fwd_priority();
    idle_inputs();
    ex_mem_rd = 5'd5; ex_mem_regwrite = 1'b1;
    mem_wb_rd = 5'd5; mem_wb_regwrite = 1'b1;
    ex_rs = {5'd5, 5'd5};
    #1;
    n_tests++;
    if (fwd_sel !== 4'b1010) begin
      n_fail++; $display("FAIL fwd_exmem_prio: fwd=%b want 1010", fwd_sel);
    end
    ex_mem_regwrite = 1'b0;
    #1;
    n_tests++;
    if (fwd_sel !== 4'b0101) begin
      n_fail++; $display("FAIL fwd_memwb: fwd=%b want 0101", fwd_sel);
    end
    ex_rs = {5'd6, 5'd5};
    #1;
    n_tests++;
    if (fwd_sel !== 4'b0001) begin
      n_fail++; $display("FAIL fwd_mixed: fwd=%b want 0001", fwd_sel);
    end
    idle_inputs();
  endtask

  task automatic test_zero_reg();
    idle_inputs();
    ex_mem_regwrite = 1'b1; mem_wb_regwrite = 1'b1; lc_wb_valid = 1'b1;
    id_ex_is_load = 1'b1; id_rs_used = 2'b11; id_regwrite = 1'b1;
    #1;
    n_tests++;
    if (fwd_sel !== 4'b0000 || stall !== 1'b0) begin
      n_fail++; $display("FAIL zero_reg: fwd=%b stall=%b want 0000 0", fwd_sel, stall);
    end
    idle_inputs();
  endtask

  task automatic test_load_use();
    idle_inputs();
    id_ex_is_load = 1'b1; id_ex_rd = 5'd7;
    id_rs = {5'd7, 5'd3}; id_rs_used = 2'b10;
    #1;
    n_tests++;
    if (stall !== 1'b1) begin
      n_fail++; $display("FAIL load_use: stall=%b want 1", stall);
    end
    id_rs_used = 2'b01;
    #1;
    n_tests++;
    if (stall !== 1'b0) begin
      n_fail++; $display("FAIL load_use_unused: stall=%b want 0", stall);
    end
    id_rs_used = 2'b11; id_ex_is_load = 1'b0;
    #1;
    n_tests++;
    if (stall !== 1'b0) begin
      n_fail++; $display("FAIL load_use_dropped: stall=%b want 0", stall);
    end
    idle_inputs();
  endtask

  task automatic test_long_raw();
    do_reset();
    issue_valid = 1'b1; issue_rd = 5'd9;
    step();
    issue_valid = 1'b0;
    id_rs = {5'd0, 5'd9}; id_rs_used = 2'b01;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_tests++;
      if (stall !== 1'b1 || outstanding !== 3'd1) begin
        n_fail++; $display("FAIL raw_wait c%0d: stall=%b out=%0d want 1 1", c, stall, outstanding);
      end
      step();
    end
    id_rs_used = 2'b00; id_regwrite = 1'b1; id_rd = 5'd9;
    #1;
    n_tests++;
    if (stall !== 1'b1) begin
      n_fail++; $display("FAIL waw: stall=%b want 1", stall);
    end
    id_regwrite = 1'b0; id_rs_used = 2'b01;
    lc_wb_valid = 1'b1; lc_wb_rd = 5'd9; ex_rs = {5'd0, 5'd9};
    #1;
    n_tests++;
    if (stall !== 1'b0 || fwd_sel !== 4'b0011) begin
      n_fail++; $display("FAIL raw_release: stall=%b fwd=%b want 0 0011", stall, fwd_sel);
    end
    step();
    idle_inputs();
    #1;
    n_tests++;
    if (outstanding !== 3'd0 || sb_err !== 1'b0) begin
      n_fail++; $display("FAIL raw_retire: out=%0d err=%b want 0 0", outstanding, sb_err);
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int r = 1; r <= 4; r++) begin
      issue_valid = 1'b1; issue_rd = 5'(r);
      step();
    end
    issue_valid = 1'b0; id_is_long = 1'b1;
    #1;
    n_tests++;
    if (stall !== 1'b1 || outstanding !== 3'd4) begin
      n_fail++; $display("FAIL full_stall: stall=%b out=%0d want 1 4", stall, outstanding);
    end
    id_is_long = 1'b0;
    #1;
    n_tests++;
    if (stall !== 1'b0) begin
      n_fail++; $display("FAIL full_short_op: stall=%b want 0", stall);
    end
    issue_valid = 1'b1; issue_rd = 5'd5; lc_wb_valid = 1'b1; lc_wb_rd = 5'd1;
    step();
    lc_wb_valid = 1'b0; issue_valid = 1'b0;
    n_tests++;
    if (outstanding !== 3'd4 || sb_err !== 1'b0) begin
      n_fail++; $display("FAIL full_swap: out=%0d err=%b want 4 0", outstanding, sb_err);
    end
    issue_valid = 1'b1; issue_rd = 5'd6;
    step();
    issue_valid = 1'b0;
    n_tests++;
    if (outstanding !== 3'd4 || sb_err !== 1'b1) begin
      n_fail++; $display("FAIL full_overflow: out=%0d err=%b want 4 1", outstanding, sb_err);
    end
  endtask

  task automatic test_sb_err();
    do_reset();
    issue_valid = 1'b1; issue_rd = 5'd3;
    step();
    issue_valid = 1'b0; lc_wb_valid = 1'b1; lc_wb_rd = 5'd12;
    step();
    lc_wb_valid = 1'b0;
    n_tests++;
    if (sb_err !== 1'b1 || outstanding !== 3'd1) begin
      n_fail++; $display("FAIL spurious_wb: err=%b out=%0d want 1 1", sb_err, outstanding);
    end
    step();
    n_tests++;
    if (sb_err !== 1'b1) begin
      n_fail++; $display("FAIL err_sticky: err=%b want 1", sb_err);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_tests++;
    if (sb_err !== 1'b0 || outstanding !== 3'd0) begin
      n_fail++; $display("FAIL err_reset: err=%b out=%0d want 0 0", sb_err, outstanding);
    end
  endtask

  // Reference model: the set of registers awaiting a long-op result.
  bit m_pend[32];
  bit m_err;

  function automatic int in_flight();
    int n = 0;
    for (int r = 0; r < 32; r++) n += int'(m_pend[r]);
    return n;
  endfunction

  task automatic test_random();
    logic [3:0] exp_fwd;
    logic       exp_stall;
    do_reset();
    foreach (m_pend[r]) m_pend[r] = 1'b0;
    m_err = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst_n           = ($urandom_range(99) >= 3);
      ex_rs           = {5'($urandom_range(7)), 5'($urandom_range(7))};
      ex_mem_rd       = 5'($urandom_range(7));
      ex_mem_regwrite = 1'($urandom);
      mem_wb_rd       = 5'($urandom_range(7));
      mem_wb_regwrite = 1'($urandom);
      id_rs           = {5'($urandom_range(7)), 5'($urandom_range(7))};
      id_rs_used      = 2'($urandom);
      id_rd           = 5'($urandom_range(7));
      id_regwrite     = 1'($urandom);
      id_is_long      = 1'($urandom);
      id_ex_rd        = 5'($urandom_range(7));
      id_ex_is_load   = ($urandom_range(3) == 0);
      issue_valid     = ($urandom_range(2) == 0);
      issue_rd        = 5'($urandom_range(7));
      lc_wb_valid     = ($urandom_range(2) == 0);
      lc_wb_rd        = 5'($urandom_range(7));
      #1;
      exp_stall = 1'b0;
      for (int i = 0; i < 2; i++) begin
        int er = int'(ex_rs[i*5 +: 5]);
        int ir = int'(id_rs[i*5 +: 5]);
        logic [1:0] s = 2'b00;
        if (er != 0) begin
          if (ex_mem_regwrite && int'(ex_mem_rd) == er) s = 2'b10;
          else if (mem_wb_regwrite && int'(mem_wb_rd) == er) s = 2'b01;
          else if (lc_wb_valid && int'(lc_wb_rd) == er) s = 2'b11;
        end
        exp_fwd[i*2 +: 2] = s;
        if (id_rs_used[i] && ir != 0) begin
          if (id_ex_is_load && int'(id_ex_rd) == ir) exp_stall = 1'b1;
          if (m_pend[ir] && !(lc_wb_valid && int'(lc_wb_rd) == ir)) exp_stall = 1'b1;
        end
      end
      if (id_regwrite && id_rd != 0 && m_pend[id_rd]) exp_stall = 1'b1;
      if (id_is_long && in_flight() == 4) exp_stall = 1'b1;
      n_tests++;
      if (fwd_sel !== exp_fwd || stall !== exp_stall || outstanding !== 3'(in_flight())
          || sb_err !== m_err) begin
        n_fail++;
        $display("FAIL random c%0d: fwd=%b stall=%b out=%0d err=%b want %b %b %0d %b",
                 cyc, fwd_sel, stall, outstanding, sb_err, exp_fwd, exp_stall,
                 in_flight(), m_err);
      end
      if (!rst_n) begin
        foreach (m_pend[r]) m_pend[r] = 1'b0;
        m_err = 1'b0;
      end else begin
        bit retire  = lc_wb_valid && m_pend[lc_wb_rd];
        bit reissue = m_pend[issue_rd] && !(retire && lc_wb_rd == issue_rd);
        bit no_room = (in_flight() == 4) && !retire;
        if ((lc_wb_valid && !m_pend[lc_wb_rd]) || (issue_valid && (reissue || no_room)))
          m_err = 1'b1;
        if (retire) m_pend[lc_wb_rd] = 1'b0;
        if (issue_valid && issue_rd != 0 && !reissue && !no_room) m_pend[issue_rd] = 1'b1;
      end
      step();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_fwd_priority();
    test_zero_reg();
    test_load_use();
    test_long_raw();
    test_full();
    test_sb_err();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
